// File: rtl/sa_tile_matmul.sv
// sa_tile_matmul: tiled, accumulating matmul sequencer between the SRAM buffers and the systolic array.
// Optional macro SA_TILE_SAT_EN selects signed-saturating accumulation; otherwise sums wrap.
module sa_tile_matmul #(
   parameter int WIDTH  = 8,
   parameter int ROW    = 4,
   parameter int COL    = 4,
   parameter int I_SIZE = 256,
   parameter int W_SIZE = 64,
   parameter int O_SIZE = 64,
   parameter int MAX_KT = 16,
   parameter int LAT    = 8
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          start_i,
   input  logic [$clog2(MAX_KT+1)-1:0]   cfg_ktiles_i,
   input  logic [$clog2(O_SIZE+1)-1:0]   cfg_mlen_i,
   input  logic                          cfg_relu_i,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          wb_mem_cenb_o,
   output logic [$clog2(W_SIZE)-1:0]     wb_mem_addr_o,
   input  logic [COL*WIDTH-1:0]          wb_mem_data_i,
   output logic                          ib_mem_cenb_o,
   output logic [$clog2(I_SIZE)-1:0]     ib_mem_addr_o,
   input  logic [ROW*WIDTH-1:0]          ib_mem_data_i,
   output logic                          ps_rd_cenb_o,
   output logic [$clog2(O_SIZE)-1:0]     ps_rd_addr_o,
   input  logic [COL*WIDTH-1:0]          ps_rd_data_i,
   output logic                          ps_wr_cenb_o,
   output logic [$clog2(O_SIZE)-1:0]     ps_wr_addr_o,
   output logic [COL*WIDTH-1:0]          ps_wr_data_o,
   output logic                          ob_mem_cenb_o,
   output logic [$clog2(O_SIZE)-1:0]     ob_mem_addr_o,
   output logic [COL*WIDTH-1:0]          ob_mem_data_o,
   output logic                          arr_mode_o,
   output logic [ROW*WIDTH-1:0]          arr_act_o,
   output logic [COL*WIDTH-1:0]          arr_weight_o,
   input  logic [COL*WIDTH-1:0]          arr_psum_i
);

   localparam int KW  = $clog2(MAX_KT+1);
   localparam int MLW = $clog2(O_SIZE+1);
   localparam int WAW = $clog2(W_SIZE);
   localparam int IAW = $clog2(I_SIZE);
   localparam int OAW = $clog2(O_SIZE);
   localparam int RW  = $clog2(ROW+1);

   typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

   typedef struct packed {
      logic           valid;
      logic [OAW-1:0] m;
      logic           first;
      logic           last;
   } tag_t;

   state_t         state, state_next;
   logic [KW-1:0]  ktiles, kt;
   logic [MLW-1:0] mlen, m_cnt;
   logic           relu;
   logic [RW-1:0]  r_cnt;
   logic [WAW-1:0] w_base;
   logic [IAW-1:0] i_base;
   logic           mode_q;
   tag_t           pipe [1:LAT];
   tag_t           issue_tag;
   logic           pipe_busy;
   logic           last_tile;
   logic           empty_job;
   logic [COL*WIDTH-1:0] sum_row, out_row;

   assign last_tile = (kt == ktiles - KW'(1));
   assign empty_job = (cfg_ktiles_i == '0) || (cfg_mlen_i == '0);

   // The tag in the final stage retires this cycle, so only earlier stages hold DRAIN.
   always_comb begin
      pipe_busy = 1'b0;
      for (int i = 1; i < LAT; i++) pipe_busy = pipe_busy | pipe[i].valid;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_i) state_next = empty_job ? DONE : LOAD_W;
         LOAD_W:  if (r_cnt == RW'(ROW-1)) state_next = STREAM;
         STREAM:  if (m_cnt == mlen - MLW'(1)) state_next = DRAIN;
         DRAIN:   if (!pipe_busy) state_next = last_tile ? DONE : LOAD_W;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state  <= IDLE;
         ktiles <= '0;
         mlen   <= '0;
         relu   <= 1'b0;
         kt     <= '0;
         m_cnt  <= '0;
         r_cnt  <= '0;
         w_base <= '0;
         i_base <= '0;
         mode_q <= 1'b0;
      end else begin
         state  <= state_next;
         mode_q <= (state == LOAD_W);
         case (state)
            IDLE: if (start_i) begin
               ktiles <= cfg_ktiles_i;
               mlen   <= cfg_mlen_i;
               relu   <= cfg_relu_i;
               kt     <= '0;
               w_base <= '0;
               i_base <= '0;
               r_cnt  <= '0;
               m_cnt  <= '0;
            end
            LOAD_W: r_cnt <= (state_next == STREAM) ? '0 : r_cnt + RW'(1);
            STREAM: m_cnt <= (state_next == DRAIN) ? '0 : m_cnt + MLW'(1);
            DRAIN: if (state_next == LOAD_W) begin
               kt     <= kt + KW'(1);
               w_base <= w_base + WAW'(ROW);
               i_base <= i_base + IAW'(mlen);
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      issue_tag       = '0;
      issue_tag.valid = (state == STREAM);
      issue_tag.m     = OAW'(m_cnt);
      issue_tag.first = (kt == '0);
      issue_tag.last  = last_tile;
   end

   // Tag pipe mirrors the array latency so each result row knows its row index and tile role.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 1; i <= LAT; i++) pipe[i] <= '0;
      end else begin
         pipe[1] <= issue_tag;
         for (int i = 2; i <= LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   function automatic logic [WIDTH-1:0] acc_add(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef SA_TILE_SAT_EN
      logic [WIDTH:0] s;
      s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
      if (s[WIDTH] != s[WIDTH-1])
         acc_add = s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      else
         acc_add = s[WIDTH-1:0];
`else
      acc_add = a + b;
`endif
   endfunction

   always_comb begin
      sum_row = '0;
      out_row = '0;
      for (int c = 0; c < COL; c++) begin
         sum_row[c*WIDTH +: WIDTH] = acc_add(arr_psum_i[c*WIDTH +: WIDTH],
                                             pipe[LAT].first ? '0 : ps_rd_data_i[c*WIDTH +: WIDTH]);
         out_row[c*WIDTH +: WIDTH] = (relu && sum_row[c*WIDTH+WIDTH-1]) ? '0 : sum_row[c*WIDTH +: WIDTH];
      end
   end

   assign busy_o        = (state != IDLE);
   assign done_o        = (state == DONE);
   assign arr_mode_o    = mode_q;
   assign arr_act_o     = ib_mem_data_i;
   assign arr_weight_o  = wb_mem_data_i;

   assign wb_mem_cenb_o = !(state == LOAD_W);
   assign wb_mem_addr_o = w_base + WAW'(r_cnt);
   assign ib_mem_cenb_o = !(state == STREAM);
   assign ib_mem_addr_o = i_base + IAW'(m_cnt);

   // Psum is fetched one stage early so its read data lines up with the array result.
   assign ps_rd_cenb_o  = !(pipe[LAT-1].valid && !pipe[LAT-1].first);
   assign ps_rd_addr_o  = pipe[LAT-1].m;
   assign ps_wr_cenb_o  = !(pipe[LAT].valid && !pipe[LAT].last);
   assign ps_wr_addr_o  = pipe[LAT].m;
   assign ps_wr_data_o  = sum_row;
   assign ob_mem_cenb_o = !(pipe[LAT].valid && pipe[LAT].last);
   assign ob_mem_addr_o = pipe[LAT].m;
   assign ob_mem_data_o = out_row;

endmodule

// File: tb/tb_sa_tile_matmul.sv
// tb_sa_tile_matmul: directed bench with SRAM and behavioural array models around sa_tile_matmul.
// Expected values honour SA_TILE_SAT_EN when the build defines it.
module tb_sa_tile_matmul;

   localparam int WIDTH  = 8;
   localparam int ROW    = 2;
   localparam int COL    = 2;
   localparam int I_SIZE = 256;
   localparam int W_SIZE = 64;
   localparam int O_SIZE = 64;
   localparam int MAX_KT = 16;
   localparam int LAT    = 8;

   logic                        clk_i = 1'b0;
   logic                        rst_i;
   logic                        start_i;
   logic [$clog2(MAX_KT+1)-1:0] cfg_ktiles_i;
   logic [$clog2(O_SIZE+1)-1:0] cfg_mlen_i;
   logic                        cfg_relu_i;
   logic                        busy_o, done_o;
   logic                        wb_mem_cenb_o, ib_mem_cenb_o, ps_rd_cenb_o, ps_wr_cenb_o, ob_mem_cenb_o;
   logic [$clog2(W_SIZE)-1:0]   wb_mem_addr_o;
   logic [$clog2(I_SIZE)-1:0]   ib_mem_addr_o;
   logic [$clog2(O_SIZE)-1:0]   ps_rd_addr_o, ps_wr_addr_o, ob_mem_addr_o;
   logic [COL*WIDTH-1:0]        wb_mem_data_i, ps_rd_data_i, ps_wr_data_o, ob_mem_data_o;
   logic [ROW*WIDTH-1:0]        ib_mem_data_i, arr_act_o;
   logic [COL*WIDTH-1:0]        arr_weight_o, arr_psum_i;
   logic                        arr_mode_o;

   logic [COL*WIDTH-1:0] wbmem [W_SIZE];
   logic [ROW*WIDTH-1:0] ibmem [I_SIZE];
   logic [COL*WIDTH-1:0] psmem [O_SIZE];
   logic [COL*WIDTH-1:0] obmem [O_SIZE];
   int ps_wr_cnt = 0;
   int ob_wr_cnt = 0;
   int acc_cnt   = 0;

   logic [WIDTH-1:0]     wreg [ROW][COL];
   int                   wl;
   logic [COL*WIDTH-1:0] dl [LAT-1];

   int total = 0;
   int bad   = 0;

   sa_tile_matmul #(
      .WIDTH(WIDTH), .ROW(ROW), .COL(COL), .I_SIZE(I_SIZE), .W_SIZE(W_SIZE),
      .O_SIZE(O_SIZE), .MAX_KT(MAX_KT), .LAT(LAT)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
      .cfg_ktiles_i(cfg_ktiles_i), .cfg_mlen_i(cfg_mlen_i), .cfg_relu_i(cfg_relu_i),
      .busy_o(busy_o), .done_o(done_o),
      .wb_mem_cenb_o(wb_mem_cenb_o), .wb_mem_addr_o(wb_mem_addr_o), .wb_mem_data_i(wb_mem_data_i),
      .ib_mem_cenb_o(ib_mem_cenb_o), .ib_mem_addr_o(ib_mem_addr_o), .ib_mem_data_i(ib_mem_data_i),
      .ps_rd_cenb_o(ps_rd_cenb_o), .ps_rd_addr_o(ps_rd_addr_o), .ps_rd_data_i(ps_rd_data_i),
      .ps_wr_cenb_o(ps_wr_cenb_o), .ps_wr_addr_o(ps_wr_addr_o), .ps_wr_data_o(ps_wr_data_o),
      .ob_mem_cenb_o(ob_mem_cenb_o), .ob_mem_addr_o(ob_mem_addr_o), .ob_mem_data_o(ob_mem_data_o),
      .arr_mode_o(arr_mode_o), .arr_act_o(arr_act_o), .arr_weight_o(arr_weight_o),
      .arr_psum_i(arr_psum_i)
   );

   always #5 clk_i = ~clk_i;

   // Synchronous SRAM models with one-cycle read latency and write counters.
   always @(posedge clk_i) begin
      if (!wb_mem_cenb_o) wb_mem_data_i <= wbmem[wb_mem_addr_o];
      if (!ib_mem_cenb_o) ib_mem_data_i <= ibmem[ib_mem_addr_o];
      if (!ps_rd_cenb_o)  ps_rd_data_i  <= psmem[ps_rd_addr_o];
      if (!ps_wr_cenb_o) begin
         psmem[ps_wr_addr_o] <= ps_wr_data_o;
         ps_wr_cnt <= ps_wr_cnt + 1;
      end
      if (!ob_mem_cenb_o) begin
         obmem[ob_mem_addr_o] <= ob_mem_data_o;
         ob_wr_cnt <= ob_wr_cnt + 1;
      end
      if (!wb_mem_cenb_o || !ib_mem_cenb_o || !ps_rd_cenb_o || !ps_wr_cenb_o || !ob_mem_cenb_o)
         acc_cnt <= acc_cnt + 1;
   end

   function automatic logic [COL*WIDTH-1:0] array_row(input logic [ROW*WIDTH-1:0] act);
      logic [COL*WIDTH-1:0] r;
      int acc;
      r = '0;
      for (int c = 0; c < COL; c++) begin
         acc = 0;
         for (int k = 0; k < ROW; k++)
            acc = acc + int'($signed(act[k*WIDTH +: WIDTH])) * int'($signed(wreg[k][c]));
         r[c*WIDTH +: WIDTH] = acc[WIDTH-1:0];
      end
      return r;
   endfunction

   // Behavioural array: latch weight rows in load mode, deliver act*W LAT cycles after the ib read issue.
   always @(posedge clk_i) begin
      if (rst_i) begin
         wl <= 0;
      end else if (arr_mode_o) begin
         for (int c = 0; c < COL; c++) wreg[wl][c] <= arr_weight_o[c*WIDTH +: WIDTH];
         wl <= (wl + 1) % ROW;
      end
      dl[0] <= array_row(arr_act_o);
      for (int k = 1; k < LAT-1; k++) dl[k] <= dl[k-1];
   end

   assign arr_psum_i = dl[LAT-2];

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Starts a job and waits for done; lat counts the start cycle as cycle 1.
   task automatic apply_stimulus(input int kt, input int ml, input bit relu, output int lat);
      int n;
      @(negedge clk_i);
      cfg_ktiles_i = kt[$clog2(MAX_KT+1)-1:0];
      cfg_mlen_i   = ml[$clog2(O_SIZE+1)-1:0];
      cfg_relu_i   = relu;
      start_i      = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      n = 2;
      while (!done_o && n < 300) begin
         @(posedge clk_i); #1;
         n++;
      end
      check_output("done_seen", {31'd0, done_o}, 32'd1);
      lat = n;
      @(posedge clk_i); #1;
      check_output("done_one_cycle", {31'd0, done_o}, 32'd0);
      check_output("idle_after_done", {31'd0, busy_o}, 32'd0);
   endtask

   function automatic logic [4:0] all_cenb();
      return {wb_mem_cenb_o, ib_mem_cenb_o, ps_rd_cenb_o, ps_wr_cenb_o, ob_mem_cenb_o};
   endfunction

   initial begin
      int lat, ps0, ob0, acc0, dones, n;
      logic [15:0] ovf_exp;
      rst_i = 1'b1; start_i = 1'b0;
      cfg_ktiles_i = '0; cfg_mlen_i = '0; cfg_relu_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      check_output("rst_busy", {31'd0, busy_o}, 32'd0);
      check_output("rst_done", {31'd0, done_o}, 32'd0);
      check_output("rst_mode", {31'd0, arr_mode_o}, 32'd0);
      check_output("rst_cenb", {27'd0, all_cenb()}, 32'h1f);
      rst_i = 1'b0;

      $display("[TB] single tile 2x2");
      wbmem[0] = 16'h0201; wbmem[1] = 16'h0403;
      ibmem[0] = 16'h0101; ibmem[1] = 16'h0002;
      ps0 = ps_wr_cnt; ob0 = ob_wr_cnt;
      apply_stimulus(1, 2, 1'b0, lat);
      check_output("s1_latency", lat, 32'd14);
      check_output("s1_ob0", obmem[0], 32'h0604);
      check_output("s1_ob1", obmem[1], 32'h0402);
      check_output("s1_ps_writes", ps_wr_cnt - ps0, 32'd0);
      check_output("s1_ob_writes", ob_wr_cnt - ob0, 32'd2);

      $display("[TB] two tiles accumulate");
      wbmem[2] = 16'h0201; wbmem[3] = 16'h0403;
      ibmem[0] = 16'h0101; ibmem[1] = 16'h0101;
      ps0 = ps_wr_cnt; ob0 = ob_wr_cnt;
      apply_stimulus(2, 1, 1'b0, lat);
      check_output("s2_ps0", psmem[0], 32'h0604);
      check_output("s2_ob0", obmem[0], 32'h0c08);
      check_output("s2_ps_writes", ps_wr_cnt - ps0, 32'd1);
      check_output("s2_ob_writes", ob_wr_cnt - ob0, 32'd1);

      $display("[TB] overflow 100+100");
      wbmem[0] = 16'h0001; wbmem[1] = 16'h0100; wbmem[2] = 16'h0001; wbmem[3] = 16'h0100;
      ibmem[0] = 16'h0064; ibmem[1] = 16'h0064;
`ifdef SA_TILE_SAT_EN
      ovf_exp = 16'h007f;
`else
      ovf_exp = 16'h00c8;
`endif
      apply_stimulus(2, 1, 1'b0, lat);
      check_output("s3_ps0", psmem[0], 32'h0064);
      check_output("s3_ob0_overflow", obmem[0], {16'd0, ovf_exp});

      $display("[TB] relu on negative column");
      ibmem[0] = 16'h03fb;
      apply_stimulus(1, 1, 1'b0, lat);
      check_output("s3_norelu", obmem[0], 32'h03fb);
      apply_stimulus(1, 1, 1'b1, lat);
      check_output("s3_relu", obmem[0], 32'h0300);

      $display("[TB] empty jobs");
      acc0 = acc_cnt;
      apply_stimulus(0, 5, 1'b0, lat);
      check_output("s4_kt0_latency", lat, 32'd2);
      apply_stimulus(3, 0, 1'b0, lat);
      check_output("s4_m0_latency", lat, 32'd2);
      check_output("s4_no_access", acc_cnt - acc0, 32'd0);

      $display("[TB] start while busy");
      wbmem[0] = 16'h0201; wbmem[1] = 16'h0403; wbmem[2] = 16'h0201; wbmem[3] = 16'h0403;
      ibmem[0] = 16'h0101; ibmem[1] = 16'h0101;
      ps0 = ps_wr_cnt; ob0 = ob_wr_cnt; dones = 0;
      @(negedge clk_i);
      cfg_ktiles_i = 2; cfg_mlen_i = 1; cfg_relu_i = 1'b0; start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (4) @(negedge clk_i);
      cfg_ktiles_i = 1; cfg_mlen_i = 2; cfg_relu_i = 1'b1; start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      for (int i = 0; i < 80; i++) begin
         @(posedge clk_i); #1;
         if (done_o) dones++;
      end
      check_output("s6_single_done", dones, 32'd1);
      check_output("s6_ob0", obmem[0], 32'h0c08);
      check_output("s6_ps_writes", ps_wr_cnt - ps0, 32'd1);
      check_output("s6_ob_writes", ob_wr_cnt - ob0, 32'd1);

      $display("[TB] reset during stream");
      ibmem[0] = 16'h0101; ibmem[1] = 16'h0002;
      @(negedge clk_i);
      cfg_ktiles_i = 1; cfg_mlen_i = 2; cfg_relu_i = 1'b0; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      n = 0;
      while (ib_mem_cenb_o && n < 20) begin
         @(posedge clk_i); #1;
         n++;
      end
      check_output("s5_stream_reached", {31'd0, ib_mem_cenb_o}, 32'd0);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      check_output("s5_busy", {31'd0, busy_o}, 32'd0);
      check_output("s5_cenb", {27'd0, all_cenb()}, 32'h1f);
      rst_i = 1'b0;
      ps0 = ps_wr_cnt; ob0 = ob_wr_cnt;
      apply_stimulus(1, 2, 1'b0, lat);
      check_output("s5_latency", lat, 32'd14);
      check_output("s5_ob0", obmem[0], 32'h0604);
      check_output("s5_ob1", obmem[1], 32'h0402);
      check_output("s5_ps_writes", ps_wr_cnt - ps0, 32'd0);
      check_output("s5_ob_writes", ob_wr_cnt - ob0, 32'd2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
